fpu_result_arb: RTL and testbench

//  Parametrised, registered result collector for N FPU execution units
//  (adder, multiplier, divider, ...). Each unit can have a different latency.

---
 rtl/fpu_result_arb_if.sv | 31 +++
 rtl/fpu_result_arb.sv | 131 +++++++++++++
 tb/tb_fpu_result_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_result_arb_if.sv
// Handshake/result bus between the FPU producer units, the result arbiter and its consumer.
// master = arbiter side, slave = producers/consumer side.
interface fpu_result_arb_if #(
  parameter int WIDTH   = 32,
  parameter int N_UNITS = 3,
  parameter int ID_W    = 2
);
  logic [N_UNITS-1:0]       unit_valid;
  logic [N_UNITS-1:0]       unit_ready;
  logic [N_UNITS*WIDTH-1:0] unit_res;
  logic [N_UNITS*3-1:0]     unit_flags;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_result;
  logic                     out_error;
  logic                     out_overflow;
  logic                     out_underflow;
  logic [ID_W-1:0]          out_unit;

  modport master (
    input  unit_valid, unit_res, unit_flags, out_ready,
    output unit_ready, out_valid, out_result, out_error, out_overflow,
           out_underflow, out_unit
  );

  modport slave (
    output unit_valid, unit_res, unit_flags, out_ready,
    input  unit_ready, out_valid, out_result, out_error, out_overflow,
           out_underflow, out_unit
  );
endinterface

// File: rtl/fpu_result_arb.sv
// Round-robin merge of N FPU unit results into one registered, tagged result beat; 1-cycle latency.
// Units are accepted only when the output register is empty or draining; a stalled beat holds steady.
module fpu_result_arb #(
  parameter int WIDTH   = 32,
  parameter int N_UNITS = 3,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_result_arb_if.master    bus,
  input  logic                sticky_clr,
  output logic                sticky_err,
  output logic                sticky_ovf,
  output logic                sticky_udf,
  output logic [CNT_W-1:0]    xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]  rr_ptr, ptr_d;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_vld;
  logic             can_acc;
  logic             accept;
  logic             xfer;
  logic [ID_W:0]    sum;
  logic [ID_W-1:0]  idx;

  logic [WIDTH-1:0] res_arr [N_UNITS];
  logic [2:0]       flg_arr [N_UNITS];

  logic [WIDTH-1:0] out_result_q;
  logic [2:0]       out_flags_q;
  logic [ID_W-1:0]  out_unit_q;

  for (genvar g = 0; g < N_UNITS; g++) begin : g_unpack
    assign res_arr[g] = bus.unit_res[g*WIDTH +: WIDTH];
    assign flg_arr[g] = bus.unit_flags[g*3 +: 3];
  end

  assign can_acc = (state_q == EMPTY) || bus.out_ready;
  assign accept  = can_acc && grant_vld;
  assign xfer    = (state_q == FULL) && bus.out_ready;

  // First requester at or above rr_ptr, wrapping modulo N_UNITS.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_UNITS)) sum = sum - (ID_W+1)'(N_UNITS);
      idx = sum[ID_W-1:0];
      if (!grant_vld && bus.unit_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    bus.unit_ready = '0;
    if (accept) bus.unit_ready = N_UNITS'(1) << grant_idx;
  end

  always_comb begin
    ptr_d = rr_ptr;
    if (accept) begin
      if (grant_idx == ID_W'(N_UNITS - 1)) ptr_d = '0;
      else                                 ptr_d = grant_idx + ID_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (bus.out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr  <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_unit_q   <= '0;
    end else if (accept) begin
      out_result_q <= res_arr[grant_idx];
      out_flags_q  <= flg_arr[grant_idx];
      out_unit_q   <= grant_idx;
    end
  end

  // A flag raised by this cycle's transfer survives a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_err <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_udf <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      sticky_err <= (sticky_err && !sticky_clr) || (xfer && out_flags_q[2]);
      sticky_ovf <= (sticky_ovf && !sticky_clr) || (xfer && out_flags_q[1]);
      sticky_udf <= (sticky_udf && !sticky_clr) || (xfer && out_flags_q[0]);
      if (xfer && (xfer_cnt != {CNT_W{1'b1}})) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid     = (state_q == FULL);
  assign bus.out_result    = out_result_q;
  assign bus.out_error     = out_flags_q[2];
  assign bus.out_overflow  = out_flags_q[1];
  assign bus.out_underflow = out_flags_q[0];
  assign bus.out_unit      = out_unit_q;

endmodule

// File: tb/tb_fpu_result_arb.sv
// Directed bench for fpu_result_arb: arbitration order, stall, sticky flags, async reset, counter saturation.
module tb_fpu_result_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_result_arb_if #(.WIDTH(32), .N_UNITS(3), .ID_W(2)) b ();
  fpu_result_arb_if #(.WIDTH(32), .N_UNITS(3), .ID_W(2)) b4 ();

  logic        sticky_clr, sticky_err, sticky_ovf, sticky_udf;
  logic [15:0] xfer_cnt;
  logic        sticky_clr4, sticky_err4, sticky_ovf4, sticky_udf4;
  logic [3:0]  xfer_cnt4;

  int checks = 0;
  int failures = 0;

  fpu_result_arb #(.WIDTH(32), .N_UNITS(3), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.master), .sticky_clr(sticky_clr),
    .sticky_err(sticky_err), .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf),
    .xfer_cnt(xfer_cnt)
  );

  fpu_result_arb #(.WIDTH(32), .N_UNITS(3), .ID_W(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.master), .sticky_clr(sticky_clr4),
    .sticky_err(sticky_err4), .sticky_ovf(sticky_ovf4), .sticky_udf(sticky_udf4),
    .xfer_cnt(xfer_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    b.unit_valid = '0; b.unit_res = '0; b.unit_flags = '0; b.out_ready = 1'b0;
    b4.unit_valid = '0; b4.unit_res = '0; b4.unit_flags = '0; b4.out_ready = 1'b0;
    sticky_clr = 1'b0; sticky_clr4 = 1'b0;
    do_reset();
    #1;
    checks++;
    if (b.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b exp 0", b.out_valid); end
    checks++;
    if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL reset_xfer_cnt: got %0d exp 0", xfer_cnt); end
    checks++;
    if ({sticky_err, sticky_ovf, sticky_udf} !== 3'b000) begin
      failures++; $display("FAIL reset_sticky: got %b exp 000", {sticky_err, sticky_ovf, sticky_udf});
    end
    checks++;
    if (b.unit_ready !== 3'b000) begin failures++; $display("FAIL reset_unit_ready: got %b exp 000", b.unit_ready); end
  endtask

  task automatic test_single();
    b.out_ready  = 1'b1;
    b.unit_res   = {32'h0, 32'h40400000, 32'h0};
    b.unit_flags = '0;
    b.unit_valid = 3'b010;
    #1;
    checks++;
    if (b.unit_ready !== 3'b010) begin failures++; $display("FAIL single_ready: got %b exp 010", b.unit_ready); end
    tick();
    b.unit_valid = 3'b000;
    checks++;
    if (b.out_valid !== 1'b1 || b.out_result !== 32'h40400000 || b.out_unit !== 2'd1) begin
      failures++;
      $display("FAIL single_beat: got v=%b r=%h u=%0d exp v=1 r=40400000 u=1", b.out_valid, b.out_result, b.out_unit);
    end
    tick();
    checks++;
    if (xfer_cnt !== 16'd1 || b.out_valid !== 1'b0) begin
      failures++; $display("FAIL single_xfer: got cnt=%0d v=%b exp cnt=1 v=0", xfer_cnt, b.out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    do_reset();
    b.out_ready  = 1'b1;
    b.unit_res   = {32'h00000102, 32'h00000101, 32'h00000100};
    b.unit_flags = '0;
    b.unit_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      exp_rdy = 3'b001 << (c % 3);
      checks++;
      if (b.unit_ready !== exp_rdy) begin
        failures++; $display("FAIL rr_grant[%0d]: got %b exp %b", c, b.unit_ready, exp_rdy);
      end
      tick();
      checks++;
      if (b.out_valid !== 1'b1 || b.out_unit !== 2'(c % 3) || b.out_result !== 32'h100 + 32'(c % 3)) begin
        failures++;
        $display("FAIL rr_beat[%0d]: got v=%b u=%0d r=%h exp v=1 u=%0d", c, b.out_valid, b.out_unit, b.out_result, c % 3);
      end
    end
  endtask

  task automatic test_stall();
    b.out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (b.unit_ready !== 3'b000 || b.out_valid !== 1'b1 || b.out_unit !== 2'd2 || b.out_result !== 32'h102) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b u=%0d r=%h exp rdy=000 v=1 u=2 r=102",
                 c, b.unit_ready, b.out_valid, b.out_unit, b.out_result);
      end
      tick();
    end
    b.out_ready = 1'b1;
    #1;
    checks++;
    if (b.unit_ready !== 3'b001) begin failures++; $display("FAIL stall_release_grant: got %b exp 001", b.unit_ready); end
    tick();
    checks++;
    if (b.out_unit !== 2'd0 || b.out_result !== 32'h100) begin
      failures++; $display("FAIL stall_release_beat: got u=%0d r=%h exp u=0 r=100", b.out_unit, b.out_result);
    end
    b.unit_valid = 3'b000;
    tick();
    checks++;
    if (b.out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain: got v=%b exp 0", b.out_valid); end
  endtask

  task automatic test_sticky();
    do_reset();
    b.out_ready  = 1'b1;
    b.unit_res   = {32'h7FC00000, 32'h0, 32'h0};
    b.unit_flags = {3'b100, 3'b000, 3'b000};
    b.unit_valid = 3'b100;
    tick();
    b.unit_valid = 3'b000;
    checks++;
    if (b.out_error !== 1'b1 || b.out_result !== 32'h7FC00000 || sticky_err !== 1'b0) begin
      failures++;
      $display("FAIL sticky_err_beat: got e=%b r=%h s=%b exp e=1 r=7fc00000 s=0", b.out_error, b.out_result, sticky_err);
    end
    tick();
    checks++;
    if (sticky_err !== 1'b1) begin failures++; $display("FAIL sticky_err_set: got %b exp 1", sticky_err); end
    b.unit_res   = {32'h0, 32'h0, 32'h3F800000};
    b.unit_flags = {3'b000, 3'b000, 3'b010};
    b.unit_valid = 3'b001;
    tick();
    b.unit_valid = 3'b000;
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    checks++;
    if ({sticky_err, sticky_ovf, sticky_udf} !== 3'b010) begin
      failures++; $display("FAIL sticky_clr_vs_set: got %b exp 010", {sticky_err, sticky_ovf, sticky_udf});
    end
  endtask

  task automatic test_async_reset();
    b.unit_flags = '0;
    b.unit_valid = 3'b010;
    tick();
    b.unit_valid = 3'b000;
    b.out_ready  = 1'b0;
    checks++;
    if (b.out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre: got v=%b exp 1", b.out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b.out_valid !== 1'b0 || xfer_cnt !== 16'd0 || sticky_ovf !== 1'b0 || b.out_unit !== 2'd0) begin
      failures++;
      $display("FAIL areset_clear: got v=%b cnt=%0d ovf=%b u=%0d exp 0 0 0 0", b.out_valid, xfer_cnt, sticky_ovf, b.out_unit);
    end
    b.unit_valid = 3'b111;
    #1;
    checks++;
    if (b.unit_ready !== 3'b001) begin failures++; $display("FAIL areset_ptr: got %b exp 001", b.unit_ready); end
    b.unit_valid = 3'b000;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    b4.out_ready  = 1'b1;
    b4.unit_res   = {32'h0, 32'h0, 32'h12345678};
    b4.unit_valid = 3'b001;
    for (int c = 0; c < 15; c++) tick();
    checks++;
    if (xfer_cnt4 !== 4'd14) begin failures++; $display("FAIL sat_pre: got %0d exp 14", xfer_cnt4); end
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (xfer_cnt4 !== 4'd15) begin failures++; $display("FAIL sat_hold: got %0d exp 15", xfer_cnt4); end
    b4.unit_valid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_sticky();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
